scan_decoder: RTL and testbench



---
 rtl/decoder_pkg.sv | 18 +
 rtl/scan_decoder_if.sv | 25 ++
 rtl/scan_prescaler.sv | 32 +++
 rtl/scan_decoder.sv | 77 +++++++
 tb/tb_scan_decoder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared decoder definitions: mode and polarity constants plus the
// one-hot decode helper used by the 2-to-4 decoder and scan_decoder.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam bit POL_ACTIVE_HIGH = 1'b0;
    localparam bit POL_ACTIVE_LOW  = 1'b1;

    localparam int MAX_SEL_W = 5;

    // Callers truncate the 32-bit result to their own output width.
    function automatic logic [31:0] onehot(input logic [4:0] s);
        onehot = 32'd1 << s;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Decoder bus: en/mode/sel towards the decoder, y/idx/tick back.
// master = driver of controls, slave = the decoder itself.
interface scan_decoder_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 1 << SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             tick;

    modport master (
        output en, mode, sel,
        input  y, idx, tick
    );

    modport slave (
        input  en, mode, sel,
        output y, idx, tick
    );

endinterface

// File: rtl/scan_prescaler.sv
// Prescale counter 0..PRESCALE-1 with clear and enable.
// Ports: clk, reset (sync, high), clear, enable, tick (comb, last count).
module scan_prescaler #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    // tick marks the edge on which the count wraps back to zero.
    assign tick = enable && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == CNT_MAX)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// N-to-2^N one-hot decoder with registered outputs and a scan mode.
// Ports: clk, reset (sync, high), bus (slave: en, mode, sel -> y, idx, tick).
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int PRESCALE   = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    scan_decoder_if.slave  bus
);

    localparam int OUT_W = 1 << SEL_W;
    localparam bit INV   = (ACTIVE_LOW == POL_ACTIVE_LOW);
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{INV}};

    logic             mode_q;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_n;
    logic [OUT_W-1:0] y_q;
    logic [OUT_W-1:0] y_n;
    logic [OUT_W-1:0] y_oh;
    logic             tick_q;
    logic             scan_run;
    logic             step;

    // Steady scan only once mode_q has caught up; the entry cycle
    // reloads idx from sel and restarts the prescaler instead.
    assign scan_run = (bus.mode == MODE_SCAN) && (mode_q == MODE_SCAN);

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (!scan_run),
        .enable (scan_run && bus.en),
        .tick   (step)
    );

    always_comb begin
        idx_n = idx_q;
        if (!scan_run)
            idx_n = bus.sel;
        else if (step)
            idx_n = idx_q + 1'b1;
    end

    // y is built from the next idx so y and idx stay aligned.
    always_comb begin
        y_oh = OUT_W'(onehot(5'(idx_n)));
        y_n  = bus.en ? y_oh : '0;
        if (INV)
            y_n = ~y_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_DIRECT;
            idx_q  <= '0;
            y_q    <= INACTIVE;
            tick_q <= 1'b0;
        end else begin
            mode_q <= bus.mode;
            idx_q  <= idx_n;
            y_q    <= y_n;
            tick_q <= step;
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder over three parameter sets.
// Prints one TB_RESULT summary line.
module tb_scan_decoder;

    logic clk = 1'b0;
    logic r0, r1, r2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scan_decoder_if #(.SEL_W(2)) a0 ();
    scan_decoder_if #(.SEL_W(2)) a1 ();
    scan_decoder_if #(.SEL_W(3)) a2 ();

    scan_decoder #(.SEL_W(2), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .reset(r0), .bus(a0)
    );
    scan_decoder #(.SEL_W(2), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .reset(r1), .bus(a1)
    );
    scan_decoder #(.SEL_W(3), .PRESCALE(1), .ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .reset(r2), .bus(a2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r0 = 1; r1 = 1; r2 = 1;
        a0.en = 1; a0.mode = 1; a0.sel = 2'd3;
        a1.en = 1; a1.mode = 0; a1.sel = 2'd2;
        a2.en = 1; a2.mode = 1; a2.sel = 3'd5;
        cyc();
        cyc();
        checks++;
        if (a0.y !== 4'b0000 || a0.idx !== 2'd0 || a0.tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_hi y=%b idx=%0d tick=%b exp y=0000 idx=0 tick=0",
                     a0.y, a0.idx, a0.tick);
        end
        checks++;
        if (a1.y !== 4'b1111 || a1.idx !== 2'd0 || a1.tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_lo y=%b idx=%0d tick=%b exp y=1111 idx=0 tick=0",
                     a1.y, a1.idx, a1.tick);
        end
        checks++;
        if (a2.y !== 8'h00 || a2.idx !== 3'd0 || a2.tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_w3 y=%h idx=%0d exp y=00 idx=0", a2.y, a2.idx);
        end
    endtask

    task automatic test_direct();
        logic [3:0] exp_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        a0.mode = 0; a0.en = 1; a0.sel = 2'd0;
        r0 = 0;
        for (int s = 0; s < 4; s++) begin
            a0.sel = 2'(s);
            for (int h = 0; h < 3; h++) begin
                cyc();
                checks++;
                if (a0.y !== exp_y[s] || a0.idx !== 2'(s) || a0.tick !== 1'b0) begin
                    failures++;
                    $display("FAIL direct sel=%0d y=%b idx=%0d tick=%b exp y=%b tick=0",
                             s, a0.y, a0.idx, a0.tick, exp_y[s]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] sv [3] = '{2'd3, 2'd0, 2'd2};
        logic [3:0] ev [3] = '{4'b1000, 4'b0001, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            a0.sel = sv[i];
            cyc();
            checks++;
            if (a0.y !== ev[i]) begin
                failures++;
                $display("FAIL b2b step=%0d y=%b exp=%b", i, a0.y, ev[i]);
            end
        end
    endtask

    task automatic test_scan_wrap();
        logic [1:0] ei [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
        logic [3:0] ey [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
        logic [1:0] cur;
        a0.sel = 2'd2; a0.mode = 1;
        cyc();
        checks++;
        if (a0.idx !== 2'd2 || a0.y !== 4'b0100 || a0.tick !== 1'b0) begin
            failures++;
            $display("FAIL scan_entry idx=%0d y=%b tick=%b exp idx=2 y=0100 tick=0",
                     a0.idx, a0.y, a0.tick);
        end
        cur = 2'd2;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                checks++;
                if (a0.tick !== 1'b0 || a0.idx !== cur) begin
                    failures++;
                    $display("FAIL scan_hold s=%0d c=%0d tick=%b idx=%0d exp tick=0 idx=%0d",
                             s, c, a0.tick, a0.idx, cur);
                end
            end
            cyc();
            checks++;
            if (a0.tick !== 1'b1 || a0.idx !== ei[s] || a0.y !== ey[s]) begin
                failures++;
                $display("FAIL scan_step s=%0d tick=%b idx=%0d y=%b exp tick=1 idx=%0d y=%b",
                         s, a0.tick, a0.idx, a0.y, ei[s], ey[s]);
            end
            cur = ei[s];
        end
    endtask

    task automatic test_en_freeze();
        a0.mode = 0; a0.sel = 2'd1;
        cyc();
        a0.mode = 1;
        cyc();
        cyc();
        cyc();
        a0.en = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (a0.y !== 4'b0000 || a0.tick !== 1'b0 || a0.idx !== 2'd1) begin
                failures++;
                $display("FAIL freeze cyc=%0d y=%b tick=%b idx=%0d exp y=0000 tick=0 idx=1",
                         i, a0.y, a0.tick, a0.idx);
            end
        end
        a0.en = 1;
        cyc();
        checks++;
        if (a0.y !== 4'b0010 || a0.idx !== 2'd1 || a0.tick !== 1'b0) begin
            failures++;
            $display("FAIL resume1 y=%b idx=%0d tick=%b exp y=0010 idx=1 tick=0",
                     a0.y, a0.idx, a0.tick);
        end
        cyc();
        checks++;
        if (a0.y !== 4'b0100 || a0.idx !== 2'd2 || a0.tick !== 1'b1) begin
            failures++;
            $display("FAIL resume2 y=%b idx=%0d tick=%b exp y=0100 idx=2 tick=1",
                     a0.y, a0.idx, a0.tick);
        end
    endtask

    task automatic test_reset_mid_scan();
        // idx=2, count=0 here; four edges step to 3, two more reach count=2
        for (int i = 0; i < 6; i++) cyc();
        checks++;
        if (a0.idx !== 2'd3) begin
            failures++;
            $display("FAIL pre_reset idx=%0d exp=3", a0.idx);
        end
        r0 = 1;
        a0.sel = 2'd1;
        cyc();
        checks++;
        if (a0.y !== 4'b0000 || a0.idx !== 2'd0 || a0.tick !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset y=%b idx=%0d tick=%b exp y=0000 idx=0 tick=0",
                     a0.y, a0.idx, a0.tick);
        end
        r0 = 0;
        cyc();
        checks++;
        if (a0.idx !== 2'd1 || a0.y !== 4'b0010 || a0.tick !== 1'b0) begin
            failures++;
            $display("FAIL reentry idx=%0d y=%b tick=%b exp idx=1 y=0010 tick=0",
                     a0.idx, a0.y, a0.tick);
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if (a0.tick !== 1'b0 || a0.idx !== 2'd1) begin
                failures++;
                $display("FAIL reentry_hold c=%0d tick=%b idx=%0d exp tick=0 idx=1",
                         c, a0.tick, a0.idx);
            end
        end
        cyc();
        checks++;
        if (a0.tick !== 1'b1 || a0.idx !== 2'd2) begin
            failures++;
            $display("FAIL reentry_step tick=%b idx=%0d exp tick=1 idx=2",
                     a0.tick, a0.idx);
        end
    endtask

    task automatic test_polarity();
        r1 = 0; a1.en = 1; a1.mode = 0; a1.sel = 2'd1;
        cyc();
        checks++;
        if (a1.y !== 4'b1101 || a1.idx !== 2'd1) begin
            failures++;
            $display("FAIL pol_sel1 y=%b idx=%0d exp y=1101 idx=1", a1.y, a1.idx);
        end
        a1.en = 0;
        cyc();
        checks++;
        if (a1.y !== 4'b1111) begin
            failures++;
            $display("FAIL pol_en0 y=%b exp=1111", a1.y);
        end
        a1.en = 1; a1.sel = 2'd3;
        cyc();
        checks++;
        if (a1.y !== 4'b0111) begin
            failures++;
            $display("FAIL pol_sel3 y=%b exp=0111", a1.y);
        end
        r1 = 1;
        cyc();
        checks++;
        if (a1.y !== 4'b1111 || a1.idx !== 2'd0) begin
            failures++;
            $display("FAIL pol_reset y=%b idx=%0d exp y=1111 idx=0", a1.y, a1.idx);
        end
        r1 = 0;
    endtask

    task automatic test_prescale1();
        logic [2:0] ei [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        logic [7:0] ey [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
        logic       et [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        r2 = 0; a2.en = 1; a2.mode = 0; a2.sel = 3'd6;
        cyc();
        checks++;
        if (a2.y !== 8'h40 || a2.tick !== 1'b0) begin
            failures++;
            $display("FAIL p1_direct y=%h tick=%b exp y=40 tick=0", a2.y, a2.tick);
        end
        a2.mode = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (a2.idx !== ei[i] || a2.y !== ey[i] || a2.tick !== et[i]) begin
                failures++;
                $display("FAIL p1_scan i=%0d idx=%0d y=%h tick=%b exp idx=%0d y=%h tick=%b",
                         i, a2.idx, a2.y, a2.tick, ei[i], ey[i], et[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_back_to_back();
        test_scan_wrap();
        test_en_freeze();
        test_reset_mid_scan();
        test_polarity();
        test_prescale1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
